// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a single shared divider.
// Handles the start/valid handshake, routes results to the winner and aborts stalled divides.
module div_arbiter #(
   parameter int unsigned WIDTH   = 10,
   parameter int unsigned TIMEOUT = 31
) (
   input  logic             clk,
   input  logic             sclr,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack0,
   output logic             ack1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] q0,
   output logic [WIDTH-1:0] q1,
   output logic             dvz0,
   output logic             dvz1,
   output logic             ovf0,
   output logic             ovf1,
   output logic             err0,
   output logic             err1,
   output logic [WIDTH-1:0] div_a,
   output logic [WIDTH-1:0] div_b,
   output logic             div_start,
   output logic             div_sclr,
   input  logic [WIDTH-1:0] div_q,
   input  logic             div_dvz,
   input  logic             div_ovf,
   input  logic             div_busy,
   input  logic             div_valid
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

   state_e                     state_q, state_d;
   logic                       gnt_q, gnt_d;
   logic                       ptr_q, ptr_d;
   logic [TW-1:0]              timer_q, timer_d;
   logic [WIDTH-1:0]           opa_q, opa_d, opb_q, opb_d;
   logic [1:0][WIDTH-1:0]      res_q, res_d;
   logic [1:0]                 dvz_q, dvz_d, ovf_q, ovf_d, err_q, err_d;
   logic                       timeout;

   // The divider is only ever started from StStart, so its busy flag carries no information.
   logic unused_busy;
   assign unused_busy = div_busy;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      timer_d = timer_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      dvz_d   = dvz_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      timeout = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               gnt_d   = (req0 && req1) ? ptr_q : req1;
               opa_d   = gnt_d ? a1 : a0;
               opb_d   = gnt_d ? b1 : b0;
               state_d = StStart;
            end
         end
         StStart: begin
            timer_d = '0;
            state_d = StWait;
         end
         StWait: begin
            timer_d = timer_q + 1'b1;
            if (div_valid) begin
               res_d[gnt_q] = div_q;
               dvz_d[gnt_q] = div_dvz;
               ovf_d[gnt_q] = div_ovf;
               err_d[gnt_q] = 1'b0;
               state_d      = StResp;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               // A late valid in this same cycle still wins, hence the gate on div_valid.
               timeout      = 1'b1;
               res_d[gnt_q] = '0;
               dvz_d[gnt_q] = 1'b0;
               ovf_d[gnt_q] = 1'b0;
               err_d[gnt_q] = 1'b1;
               state_d      = StResp;
            end
         end
         StResp: begin
            ptr_d   = ~gnt_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge sclr) begin
      if (sclr) begin
         state_q <= StIdle;
         gnt_q   <= 1'b0;
         ptr_q   <= 1'b0;
         timer_q <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         dvz_q   <= '0;
         ovf_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         timer_q <= timer_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         dvz_q   <= dvz_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign ack0      = (state_q == StStart) && !gnt_q;
   assign ack1      = (state_q == StStart) && gnt_q;
   assign done0     = (state_q == StResp) && !gnt_q;
   assign done1     = (state_q == StResp) && gnt_q;
   assign div_start = (state_q == StStart);
   assign div_sclr  = timeout;
   assign div_a     = opa_q;
   assign div_b     = opb_q;
   assign q0        = res_q[0];
   assign q1        = res_q[1];
   assign dvz0      = dvz_q[0];
   assign dvz1      = dvz_q[1];
   assign ovf0      = ovf_q[0];
   assign ovf1      = ovf_q[1];
   assign err0      = err_q[0];
   assign err1      = err_q[1];

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: divider model, transaction-level reference model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_div_arbiter;

   localparam int W  = 10;
   localparam int TO = 31;

   logic         clk = 1'b0;
   logic         sclr = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic [W-1:0] div_q = '0;
   logic         div_dvz = 1'b0, div_ovf = 1'b0, div_busy = 1'b0, div_valid = 1'b0;
   logic         ack0, ack1, done0, done1, dvz0, dvz1, ovf0, ovf1, err0, err1;
   logic         div_start, div_sclr;
   logic [W-1:0] q0, q1, div_a, div_b;

   div_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .sclr(sclr), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
      .q0(q0), .q1(q1), .dvz0(dvz0), .dvz1(dvz1), .ovf0(ovf0), .ovf1(ovf1),
      .err0(err0), .err1(err1), .div_a(div_a), .div_b(div_b),
      .div_start(div_start), .div_sclr(div_sclr), .div_q(div_q),
      .div_dvz(div_dvz), .div_ovf(div_ovf), .div_busy(div_busy), .div_valid(div_valid)
   );

   initial forever #5 clk = ~clk;

   int checks = 0, failures = 0;
   int cyc = 0;
   int sclr_pulses = 0;

   // divider model controls
   int           div_lat = 12;
   bit           div_hang = 1'b0;
   bit           stray = 1'b0;
   bit           pend = 1'b0;
   int           fire_at = 0;
   logic [W-1:0] da = '0, db = '0;

   // reference model: one transaction at a time, timed relative to its grant
   bit           in_txn = 1'b0, owner = 1'b0, ptr = 1'b0;
   int           start_cyc = -100, done_cyc = -1, idle_from = 0;
   logic [W-1:0] m_q [2];
   bit           m_dvz [2], m_ovf [2], m_err [2];
   logic [W-1:0] m_a = '0, m_b = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   initial begin
      m_q[0] = '0; m_q[1] = '0;
      m_dvz[0] = 0; m_dvz[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0; m_err[0] = 0; m_err[1] = 0;
      forever begin
         @(posedge clk);
         // divider: result L cycles after the start cycle, a/b or all-ones with dvz on b=0
         if (stray) begin
            div_valid <= 1'b1;
            div_q     <= 10'h155;
            div_dvz   <= 1'b0;
            stray      = 1'b0;
         end else if (sclr || div_sclr) begin
            pend       = 1'b0;
            div_valid <= 1'b0;
         end else if (pend && cyc == fire_at - 1) begin
            div_valid <= 1'b1;
            div_q     <= (db == '0) ? '1 : da / db;
            div_dvz   <= (db == '0);
            pend       = 1'b0;
         end else begin
            div_valid <= 1'b0;
         end
         if (!sclr && div_start && !div_hang) begin
            pend    = 1'b1;
            fire_at = cyc + div_lat;
            da      = div_a;
            db      = div_b;
         end
         div_busy <= pend;

         // reference model, judging the cycle that just ended
         if (sclr) begin
            in_txn = 0; ptr = 0; done_cyc = -1; start_cyc = -100; idle_from = cyc + 1;
            m_a = '0; m_b = '0;
            for (int i = 0; i < 2; i++) begin
               m_q[i] = '0; m_dvz[i] = 0; m_ovf[i] = 0; m_err[i] = 0;
            end
         end else if (in_txn && cyc == done_cyc) begin
            in_txn = 0; ptr = !owner; idle_from = cyc + 1; done_cyc = -1;
         end else if (in_txn && done_cyc < 0 && cyc > start_cyc) begin
            if (div_valid) begin
               m_q[owner] = div_q; m_dvz[owner] = div_dvz; m_ovf[owner] = div_ovf;
               m_err[owner] = 0; done_cyc = cyc + 1;
            end else if (cyc == start_cyc + TO) begin
               m_q[owner] = '0; m_dvz[owner] = 0; m_ovf[owner] = 0;
               m_err[owner] = 1; done_cyc = cyc + 1;
            end
         end else if (!in_txn && cyc >= idle_from && (req0 || req1)) begin
            owner     = (req0 && req1) ? ptr : req1;
            m_a       = owner ? a1 : a0;
            m_b       = owner ? b1 : b0;
            in_txn    = 1;
            start_cyc = cyc + 1;
         end
         cyc = cyc + 1;
      end
   end

   // every-cycle comparison against the model, sampled on the falling edge
   initial forever begin
      bit z;
      @(negedge clk);
      z = sclr;
      if (div_sclr === 1'b1) sclr_pulses++;
      chk("ack0", 32'(ack0), 32'(!z && in_txn && cyc == start_cyc && !owner));
      chk("ack1", 32'(ack1), 32'(!z && in_txn && cyc == start_cyc && owner));
      chk("div_start", 32'(div_start), 32'(!z && in_txn && cyc == start_cyc));
      chk("done0", 32'(done0), 32'(!z && in_txn && cyc == done_cyc && !owner));
      chk("done1", 32'(done1), 32'(!z && in_txn && cyc == done_cyc && owner));
      chk("div_sclr", 32'(div_sclr),
          32'(!z && in_txn && done_cyc < 0 && cyc == start_cyc + TO && !div_valid));
      chk("div_a", 32'(div_a), 32'(z ? '0 : m_a));
      chk("div_b", 32'(div_b), 32'(z ? '0 : m_b));
      chk("q0", 32'(q0), 32'(z ? '0 : m_q[0]));
      chk("q1", 32'(q1), 32'(z ? '0 : m_q[1]));
      chk("dvz0", 32'(dvz0), 32'(!z && m_dvz[0]));
      chk("dvz1", 32'(dvz1), 32'(!z && m_dvz[1]));
      chk("ovf0", 32'(ovf0), 32'(!z && m_ovf[0]));
      chk("ovf1", 32'(ovf1), 32'(!z && m_ovf[1]));
      chk("err0", 32'(err0), 32'(!z && m_err[0]));
      chk("err1", 32'(err1), 32'(!z && m_err[1]));
   end

   function automatic bit ev(input int sel);
      case (sel)
         0:       return ack0;
         1:       return ack1;
         2:       return done0;
         3:       return done1;
         4:       return div_sclr;
         default: return ack0 || ack1;
      endcase
   endfunction

   task automatic wait_ev(input int sel, input int bound, output int at);
      at = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (ev(sel)) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         checks++;
         failures++;
         $display("FAIL wait_ev sel=%0d: got no event, expected one within %0d cycles", sel, bound);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, at, s, sc, d, p;
      int ord [4];

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_q0", 32'(q0), 32'd0);
      chk("rst_q1", 32'(q1), 32'd0);
      chk("rst_div_a", 32'(div_a), 32'd0);
      chk("rst_start", 32'(div_start), 32'd0);
      step(); sclr = 1'b0;

      // single request, L=12
      step(); req0 = 1; a0 = 10'd100; b0 = 10'd7; t = cyc;
      wait_ev(0, 10, at);
      chk("t1_ack_lat", 32'(at - t), 32'd1);
      step(); req0 = 0; a0 = 10'd3;
      wait_ev(2, 40, at);
      chk("t1_done_lat", 32'(at - t), 32'd14);
      chk("t1_q0", 32'(q0), 32'd14);
      chk("t1_err0", 32'(err0), 32'd0);
      chk("t1_q1", 32'(q1), 32'd0);

      // contention straight after reset, both held high for four grants
      step(); sclr = 1;
      step(); sclr = 0;
      req0 = 1; a0 = 10'd50; b0 = 10'd5; req1 = 1; a1 = 10'd81; b1 = 10'd9;
      for (int i = 0; i < 4; i++) begin
         wait_ev(6, 60, at);
         ord[i] = int'(ack1);
      end
      step(); req0 = 0; req1 = 0;
      wait_ev(3, 60, at);
      chk("fair_0", 32'(ord[0]), 32'd0);
      chk("fair_1", 32'(ord[1]), 32'd1);
      chk("fair_2", 32'(ord[2]), 32'd0);
      chk("fair_3", 32'(ord[3]), 32'd1);
      chk("cont_q0", 32'(q0), 32'd10);
      chk("cont_q1", 32'(q1), 32'd9);

      // divide by zero on requester 1
      step(); req1 = 1; a1 = 10'd77; b1 = 10'd0;
      wait_ev(1, 10, at);
      step(); req1 = 0;
      wait_ev(3, 40, at);
      chk("dvz_dvz1", 32'(dvz1), 32'd1);
      chk("dvz_q1", 32'(q1), 32'h3ff);
      chk("dvz_dvz0", 32'(dvz0), 32'd0);
      chk("dvz_q0", 32'(q0), 32'd10);

      // stalled divider
      div_hang = 1;
      step(); req0 = 1; a0 = 10'd20; b0 = 10'd4;
      wait_ev(0, 10, s);
      step(); req0 = 0;
      wait_ev(4, 50, sc);
      chk("to_sclr_lat", 32'(sc - s), 32'd31);
      wait_ev(2, 5, d);
      chk("to_done_lat", 32'(d - sc), 32'd1);
      chk("to_err0", 32'(err0), 32'd1);
      chk("to_q0", 32'(q0), 32'd0);
      div_hang = 0;
      step(); req0 = 1;
      wait_ev(0, 10, at);
      step(); req0 = 0;
      wait_ev(2, 40, at);
      chk("to_rec_err0", 32'(err0), 32'd0);
      chk("to_rec_q0", 32'(q0), 32'd5);

      // stray valid in idle, then valid landing on the last timeout cycle
      step(); stray = 1;
      repeat (3) @(negedge clk);
      chk("stray_q0", 32'(q0), 32'd5);
      chk("stray_q1", 32'(q1), 32'h3ff);
      div_lat = 31;
      p = sclr_pulses;
      step(); req1 = 1; a1 = 10'd90; b1 = 10'd9;
      wait_ev(1, 10, s);
      step(); req1 = 0;
      wait_ev(3, 50, d);
      chk("late_done_lat", 32'(d - s), 32'd32);
      chk("late_err1", 32'(err1), 32'd0);
      chk("late_q1", 32'(q1), 32'd10);
      chk("late_no_sclr", 32'(sclr_pulses), 32'(p));

      // reset five cycles into WAIT
      div_lat = 12;
      step(); req0 = 1; a0 = 10'd9; b0 = 10'd3;
      wait_ev(0, 10, s);
      step(); req0 = 0;
      repeat (4) step();
      sclr = 1;
      #1;
      chk("rst_mid_q0", 32'(q0), 32'd0);
      chk("rst_mid_q1", 32'(q1), 32'd0);
      chk("rst_mid_div_a", 32'(div_a), 32'd0);
      chk("rst_mid_done0", 32'(done0), 32'd0);
      repeat (3) step();
      sclr = 0; req1 = 1; a1 = 10'd40; b1 = 10'd8; t = cyc;
      wait_ev(6, 10, at);
      chk("rel_ack1_first", 32'(ack1), 32'd1);
      chk("rel_ack_lat", 32'(at - t), 32'd1);
      step(); req1 = 0;
      wait_ev(3, 40, at);
      chk("rel_q1", 32'(q1), 32'd5);
      step(); req0 = 1; a0 = 10'd60; b0 = 10'd6; req1 = 1; a1 = 10'd8; b1 = 10'd2;
      wait_ev(6, 10, at);
      chk("rel_ptr_ack0", 32'(ack0), 32'd1);
      step(); req0 = 0; req1 = 0;
      wait_ev(2, 40, at);
      chk("rel_q0", 32'(q0), 32'd10);

      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
